// File: rtl/c3lib_prog_tie_pkg.sv
// Shared types and helpers for the programmable tie bus: the apply FSM state
// encoding and the sizing rule for the apply-delay counter.
package c3lib_prog_tie_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } tie_state_e;

  // Counter must hold APPLY_DLY-1; sized as clog2(APPLY_DLY+1) so it is never zero-width.
  function automatic int cnt_width(input int apply_dly);
    return (apply_dly < 1) ? 1 : $clog2(apply_dly + 1);
  endfunction

endpackage

// File: rtl/c3lib_prog_tie_ctrl.sv
// Apply sequencer for the programmable tie bus: IDLE/WAIT FSM, delay counter
// and sticky lock. commit_o marks the edge on which the active bus is loaded.
module c3lib_prog_tie_ctrl
  import c3lib_prog_tie_pkg::*;
#(
  parameter int APPLY_DLY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       apply_i,
  input  logic       lock_i,
  output logic       commit_o,
  output logic       locked_o,
  output tie_state_e state_o
);

  localparam int CW = cnt_width(APPLY_DLY);
  localparam logic [CW-1:0] CNT_LOAD = CW'(APPLY_DLY - 1);

  tie_state_e    state_q;
  logic [CW-1:0] cnt_q;
  logic          lk_q;

  // Handshake: apply_i is a single-cycle request with no ready; it is taken only
  // in IDLE while unlocked, otherwise dropped. commit_o pulses for one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lk_q    <= 1'b0;
    end else begin
      if (lock_i) lk_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (apply_i && !lk_q) begin
            state_q <= WAIT;
            cnt_q   <= CNT_LOAD;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
      endcase
    end
  end

  assign commit_o = (state_q == WAIT) && (cnt_q == '0);
  assign locked_o = lk_q;
  assign state_o  = state_q;

endmodule

// File: rtl/c3lib_prog_tie_bus.sv
// Run-time programmable tie bus: masked staging register, delayed atomic apply
// into the active bus, and a sticky lock that freezes both until reset.
module c3lib_prog_tie_bus
  import c3lib_prog_tie_pkg::*;
#(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] TIE_VALUE = 4'b0011,
  parameter int               APPLY_DLY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [WIDTH-1:0] wr_mask,
  input  logic             apply,
  input  logic             lock,
  output logic [WIDTH-1:0] out,
  output logic             pend,
  output logic             busy,
  output logic             locked
);

  if (WIDTH < 1 || APPLY_DLY < 1 || $bits(TIE_VALUE) != WIDTH) begin : g_param_check
    $error("c3lib_prog_tie_bus: illegal WIDTH/APPLY_DLY/TIE_VALUE");
  end

  logic [WIDTH-1:0] stg_q;
  logic [WIDTH-1:0] stg_d;
  logic [WIDTH-1:0] act_q;
  logic             commit;
  tie_state_e       ctrl_state;

  c3lib_prog_tie_ctrl #(
    .APPLY_DLY(APPLY_DLY)
  ) u_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .apply_i (apply),
    .lock_i  (lock),
    .commit_o(commit),
    .locked_o(locked),
    .state_o (ctrl_state)
  );

  // Lock gates writes on its pre-edge value, so a write alongside lock still lands.
  always_comb begin
    stg_d = stg_q;
    if (wr_en && !locked) stg_d = (stg_q & ~wr_mask) | (wr_data & wr_mask);
  end

  // Commit copies the pre-edge staging value; a write on the same edge waits for the next apply.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stg_q <= TIE_VALUE;
      act_q <= TIE_VALUE;
    end else begin
      stg_q <= stg_d;
      if (commit) act_q <= stg_q;
    end
  end

  assign out  = act_q;
  assign pend = (stg_q != act_q);
  assign busy = (ctrl_state == WAIT);

endmodule

// File: tb/tb_c3lib_prog_tie_bus.sv
// Directed bench for c3lib_prog_tie_bus: a vector table on the default instance,
// plus latency sequences on WIDTH=16/APPLY_DLY=7 and WIDTH=1/APPLY_DLY=1 instances.
module tb_c3lib_prog_tie_bus;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Default instance (WIDTH=4, TIE=0011, APPLY_DLY=2)
  logic       rst_n_a = 1'b0, wr_en_a = 1'b0, apply_a = 1'b0, lock_a = 1'b0;
  logic [3:0] wr_data_a = '0, wr_mask_a = '0, out_a;
  logic       pend_a, busy_a, locked_a;

  c3lib_prog_tie_bus dut_a (
    .clk(clk), .rst_n(rst_n_a), .wr_en(wr_en_a), .wr_data(wr_data_a), .wr_mask(wr_mask_a),
    .apply(apply_a), .lock(lock_a), .out(out_a), .pend(pend_a), .busy(busy_a), .locked(locked_a)
  );

  // Wide, long-delay instance
  logic        rst_n_b = 1'b0, wr_en_b = 1'b0, apply_b = 1'b0, lock_b = 1'b0;
  logic [15:0] wr_data_b = '0, wr_mask_b = '0, out_b;
  logic        pend_b, busy_b, locked_b;

  c3lib_prog_tie_bus #(.WIDTH(16), .TIE_VALUE(16'hA5C3), .APPLY_DLY(7)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .wr_en(wr_en_b), .wr_data(wr_data_b), .wr_mask(wr_mask_b),
    .apply(apply_b), .lock(lock_b), .out(out_b), .pend(pend_b), .busy(busy_b), .locked(locked_b)
  );

  // Single-bit, minimum-delay instance
  logic rst_n_c = 1'b0, wr_en_c = 1'b0, apply_c = 1'b0, lock_c = 1'b0;
  logic wr_data_c = 1'b0, wr_mask_c = 1'b0, out_c;
  logic pend_c, busy_c, locked_c;

  c3lib_prog_tie_bus #(.WIDTH(1), .TIE_VALUE(1'b1), .APPLY_DLY(1)) dut_c (
    .clk(clk), .rst_n(rst_n_c), .wr_en(wr_en_c), .wr_data(wr_data_c), .wr_mask(wr_mask_c),
    .apply(apply_c), .lock(lock_c), .out(out_c), .pend(pend_c), .busy(busy_c), .locked(locked_c)
  );

  typedef struct {
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_data;
    logic [3:0] wr_mask;
    logic       apply;
    logic       lock;
    logic [3:0] e_out;
    logic       e_pend;
    logic       e_busy;
    logic       e_locked;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rn, input logic we, input logic [3:0] wd,
                              input logic [3:0] wm, input logic ap, input logic lk,
                              input logic [3:0] eo, input logic ep, input logic eb,
                              input logic el);
    vecs.push_back('{rn, we, wd, wm, ap, lk, eo, ep, eb, el});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    //  rst we  data     mask     ap lk   out      pend busy lkd
    add(0, 0, 4'b0000, 4'b0000, 0, 0,  4'b0011, 0, 0, 0); // 0 reset
    add(1, 0, 4'b0000, 4'b0000, 0, 0,  4'b0011, 0, 0, 0); // 1 idle
    add(1, 1, 4'b1100, 4'b0110, 0, 0,  4'b0011, 1, 0, 0); // 2 masked write -> stg 0101
    add(1, 0, 4'b0000, 4'b0000, 1, 0,  4'b0011, 1, 1, 0); // 3 apply at t
    add(1, 0, 4'b0000, 4'b0000, 1, 0,  4'b0011, 1, 1, 0); // 4 apply in WAIT dropped
    add(1, 0, 4'b0000, 4'b0000, 0, 0,  4'b0101, 0, 0, 0); // 5 commit at t+2
    add(1, 0, 4'b0000, 4'b0000, 1, 0,  4'b0101, 0, 1, 0); // 6 apply at t+3 accepted
    add(1, 0, 4'b0000, 4'b0000, 0, 0,  4'b0101, 0, 1, 0); // 7
    add(1, 1, 4'b1111, 4'b1111, 0, 0,  4'b0101, 1, 0, 0); // 8 write on commit edge
    add(1, 0, 4'b0000, 4'b0000, 1, 0,  4'b0101, 1, 1, 0); // 9 apply
    add(1, 0, 4'b0000, 4'b0000, 0, 1,  4'b0101, 1, 1, 1); // 10 lock during WAIT
    add(1, 0, 4'b0000, 4'b0000, 0, 0,  4'b1111, 0, 0, 1); // 11 in-flight commit lands
    add(1, 1, 4'b0000, 4'b1111, 0, 0,  4'b1111, 0, 0, 1); // 12 write while locked
    add(1, 0, 4'b0000, 4'b0000, 1, 0,  4'b1111, 0, 0, 1); // 13 apply while locked
    add(0, 0, 4'b0000, 4'b0000, 0, 0,  4'b0011, 0, 0, 0); // 14 re-reset
    add(1, 1, 4'b1000, 4'b1000, 0, 1,  4'b0011, 1, 0, 1); // 15 write + lock same edge
    add(1, 0, 4'b0000, 4'b0000, 1, 0,  4'b0011, 1, 0, 1); // 16 apply dropped (locked)
    add(0, 0, 4'b0000, 4'b0000, 0, 0,  4'b0011, 0, 0, 0); // 17 reset
    add(1, 0, 4'b0000, 4'b0000, 1, 1,  4'b0011, 0, 1, 1); // 18 apply + lock same edge
    add(0, 0, 4'b0000, 4'b0000, 0, 0,  4'b0011, 0, 0, 0); // 19 reset mid-WAIT
    add(1, 1, 4'b0100, 4'b0100, 1, 0,  4'b0011, 1, 1, 0); // 20 apply + write -> stg 0111
    add(1, 1, 4'b0000, 4'b0001, 0, 0,  4'b0011, 1, 1, 0); // 21 write in WAIT -> stg 0110
    add(1, 0, 4'b0000, 4'b0000, 0, 0,  4'b0110, 0, 0, 0); // 22 commit uses latest stg
    add(1, 0, 4'b0000, 4'b0000, 1, 0,  4'b0110, 0, 1, 0); // 23 apply
    add(0, 0, 4'b0000, 4'b0000, 0, 0,  4'b0011, 0, 0, 0); // 24 reset aborts apply
    add(1, 0, 4'b0000, 4'b0000, 0, 0,  4'b0011, 0, 0, 0); // 25 no late commit
    add(1, 0, 4'b0000, 4'b0000, 0, 0,  4'b0011, 0, 0, 0); // 26

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n_a   = vecs[i].rst_n;
      wr_en_a   = vecs[i].wr_en;
      wr_data_a = vecs[i].wr_data;
      wr_mask_a = vecs[i].wr_mask;
      apply_a   = vecs[i].apply;
      lock_a    = vecs[i].lock;
      step();
      if (i == 0) begin
        rst_n_b = 1'b1;
        rst_n_c = 1'b1;
      end
      chk($sformatf("v%0d.out", i), 32'(out_a), 32'(vecs[i].e_out));
      chk($sformatf("v%0d.pend", i), 32'(pend_a), 32'(vecs[i].e_pend));
      chk($sformatf("v%0d.busy", i), 32'(busy_a), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d.locked", i), 32'(locked_a), 32'(vecs[i].e_locked));
    end

    // WIDTH=16, APPLY_DLY=7: busy from edge t through t+6, commit at t+7
    chk("b.reset_out", 32'(out_b), 32'h0000A5C3);
    wr_en_b = 1'b1; wr_data_b = 16'h1234; wr_mask_b = 16'hFFFF;
    step();
    wr_en_b = 1'b0;
    chk("b.pend_after_wr", 32'(pend_b), 32'd1);
    apply_b = 1'b1;
    step();
    apply_b = 1'b0;
    chk("b.busy_t", 32'(busy_b), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("b.busy_t%0d", k), 32'(busy_b), 32'd1);
      chk($sformatf("b.out_t%0d", k), 32'(out_b), 32'h0000A5C3);
    end
    step();
    chk("b.busy_t7", 32'(busy_b), 32'd0);
    chk("b.out_t7", 32'(out_b), 32'h00001234);
    chk("b.pend_t7", 32'(pend_b), 32'd0);
    chk("b.locked", 32'(locked_b), 32'd0);

    // WIDTH=1, APPLY_DLY=1: commit one edge after apply, re-apply at t+2
    chk("c.reset_out", 32'(out_c), 32'd1);
    wr_en_c = 1'b1; wr_data_c = 1'b0; wr_mask_c = 1'b1;
    step();
    wr_en_c = 1'b0;
    apply_c = 1'b1;
    step();
    chk("c.busy_t", 32'(busy_c), 32'd1);
    chk("c.out_t", 32'(out_c), 32'd1);
    step();
    apply_c = 1'b0;
    chk("c.busy_t1", 32'(busy_c), 32'd0);
    chk("c.out_t1", 32'(out_c), 32'd0);
    chk("c.pend_t1", 32'(pend_c), 32'd0);
    wr_en_c = 1'b1; wr_data_c = 1'b1; apply_c = 1'b1;
    step();
    wr_en_c = 1'b0; apply_c = 1'b0;
    chk("c.busy_t2", 32'(busy_c), 32'd1);
    chk("c.pend_t2", 32'(pend_c), 32'd1);
    chk("c.out_t2", 32'(out_c), 32'd0);
    step();
    chk("c.out_t3", 32'(out_c), 32'd1);
    chk("c.busy_t3", 32'(busy_c), 32'd0);
    chk("c.locked", 32'(locked_c), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
